// File: rtl/piso.sv
// -----------------------------------------------------------------------------
// piso - parallel-in serial-out shift register with valid/ready load handshake
//
// Accepts a WIDTH-bit word on a valid/ready handshake and emits it one bit per
// clock, flagging each bit with valid_o and the final bit of the word with
// last_o. A one-entry holding register absorbs the next word while the current
// one is still shifting, so consecutive words stream with no idle cycle.
//
// Parameters:
//   WIDTH      word width in bits (>= 1)
//   LSB_FIRST  1: bit 0 is sent first; 0: bit WIDTH-1 is sent first
//
// Ports:
//   clk_i     clock, all logic on the rising edge
//   rst_n_i   asynchronous active-low reset
//   valid_i   parallel word on data_i is valid
//   data_i    parallel word to serialise
//   ready_o   block can accept a word (transfer when valid_i & ready_o)
//   data_o    serial data bit (0 whenever valid_o is low)
//   valid_o   data_o carries a valid bit this cycle
//   last_o    data_o is the final bit of the current word
// -----------------------------------------------------------------------------
module piso #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             data_o,
    output logic             valid_o,
    output logic             last_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [WIDTH-1:0]  shift_reg, shift_next;
    logic [WIDTH-1:0]  hold_reg, hold_next;
    logic              hold_full_reg, hold_full_next;
    logic              ready_en_reg;

    // Incoming word rearranged so the first bit to transmit sits at index 0.
    // Both the shift register and the holding register store words in this
    // order, so the datapath always shifts right and emits bit 0 regardless
    // of LSB_FIRST.
    logic [WIDTH-1:0]  data_ordered;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_order
            if (LSB_FIRST) begin : g_lsb
                assign data_ordered[gi] = data_i[gi];
            end else begin : g_msb
                assign data_ordered[gi] = data_i[WIDTH-1-gi];
            end
        end
    endgenerate

    logic accept;
    logic last_bit;
    logic end_of_word;

    // ready_en_reg holds ready_o low during reset and for the first cycle
    // after release; from then on ready only depends on the holding register.
    assign ready_o     = ready_en_reg & ~hold_full_reg;
    assign accept      = valid_i & ready_o;
    assign last_bit    = (cnt_reg == LAST_CNT);
    assign end_of_word = (state_reg == SHIFT) & last_bit;

    // Outputs are decoded straight from state so that an asynchronous reset
    // clears them immediately without waiting for a clock edge.
    assign valid_o = (state_reg == SHIFT);
    assign last_o  = end_of_word;
    assign data_o  = (state_reg == SHIFT) ? shift_reg[0] : 1'b0;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        shift_next     = shift_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;

        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    shift_next = data_ordered;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
                if (last_bit) begin
                    cnt_next = '0;
                    if (hold_full_reg) begin
                        // Drain the held word; ready_o rises next cycle.
                        shift_next     = hold_reg;
                        hold_full_next = 1'b0;
                    end else if (accept) begin
                        // Word arriving on the final-bit cycle goes straight
                        // into the shift register, bypassing the hold slot.
                        shift_next = data_ordered;
                    end else begin
                        shift_next = '0;
                        state_next = IDLE;
                    end
                end else begin
                    shift_next = shift_reg >> 1;
                    cnt_next   = cnt_reg + 1'b1;
                    // ready_o is low while the hold slot is full, so accept
                    // here can only find the slot empty.
                    if (accept) begin
                        hold_next      = data_ordered;
                        hold_full_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            ready_en_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shift_reg     <= shift_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            ready_en_reg  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_piso.sv
// -----------------------------------------------------------------------------
// tb_piso - directed bench for piso
//
// Two instances share clock and reset: u_dut (WIDTH=4, LSB first) and
// u_dut8 (WIDTH=8, MSB first). Inputs are driven and outputs sampled 1 time
// unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_piso;

    logic       clk_i;
    logic       rst_n_i;

    logic       valid_i;
    logic [3:0] data_i;
    logic       ready_o;
    logic       data_o;
    logic       valid_o;
    logic       last_o;

    logic       valid8_i;
    logic [7:0] data8_i;
    logic       ready8_o;
    logic       data8_o;
    logic       valid8_o;
    logic       last8_o;

    int checks;
    int failures;

    piso #(.WIDTH(4), .LSB_FIRST(1'b1)) u_dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .last_o  (last_o)
    );

    piso #(.WIDTH(8), .LSB_FIRST(1'b0)) u_dut8 (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .valid_i (valid8_i),
        .data_i  (data8_i),
        .ready_o (ready8_o),
        .data_o  (data8_o),
        .valid_o (valid8_o),
        .last_o  (last8_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_idle4(input string tag);
        check({tag, "_valid"}, valid_o, 1'b0);
        check({tag, "_data"},  data_o,  1'b0);
        check({tag, "_last"},  last_o,  1'b0);
    endtask

    // Expected serial streams, indexed by output cycle.
    logic [7:0]  exp3_data;
    logic [7:0]  exp3_rdy;
    logic [7:0]  exp4_data;
    logic [15:0] exp6_data;
    logic [3:0]  exp2_data;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n_i  = 1'b0;
        valid_i  = 1'b0;
        data_i   = '0;
        valid8_i = 1'b0;
        data8_i  = '0;

        // ---------------- 1: reset ----------------
        #1;
        for (int i = 0; i < 3; i++) begin
            check_idle4($sformatf("rst%0d", i));
            check($sformatf("rst%0d_ready", i), ready_o, 1'b0);
            tick();
        end
        rst_n_i = 1'b1;
        check("rel_ready_before_edge", ready_o, 1'b0);
        tick();
        check("rel_ready", ready_o, 1'b1);
        check("rel_ready8", ready8_o, 1'b1);
        check_idle4("rel");
        $display("txn reset released checks=%0d", checks);

        // ---------------- 2: single word 4'b1011 ----------------
        exp2_data = 4'b1011;
        valid_i = 1'b1;
        data_i  = 4'b1011;
        tick();
        valid_i = 1'b0;
        data_i  = 4'b0000;      // later changes must not affect the word
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_data%0d", i),  data_o,  exp2_data[i]);
            check($sformatf("t2_valid%0d", i), valid_o, 1'b1);
            check($sformatf("t2_last%0d", i),  last_o,  (i == 3));
            tick();
        end
        check_idle4("t2_end");
        check("t2_end_ready", ready_o, 1'b1);
        $display("txn single word 4'hb done checks=%0d", checks);

        // ---------------- 3: back-to-back A then 5 ----------------
        exp3_data = 8'b0101_1010;   // bit i = expected data on cycle i
        exp3_rdy  = 8'b1111_0001;
        valid_i = 1'b1;
        data_i  = 4'hA;
        tick();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_data%0d", i),  data_o,  exp3_data[i]);
            check($sformatf("t3_valid%0d", i), valid_o, 1'b1);
            check($sformatf("t3_last%0d", i),  last_o,  (i == 3 || i == 7));
            check($sformatf("t3_ready%0d", i), ready_o, exp3_rdy[i]);
            if (i == 0) data_i = 4'h5;
            if (i == 1) valid_i = 1'b0;
            tick();
        end
        check_idle4("t3_end");
        $display("txn back-to-back 4'ha,4'h5 done checks=%0d", checks);

        // ---------------- 4: bypass 3 then C on last cycle ----------------
        exp4_data = 8'b1100_0011;
        valid_i = 1'b1;
        data_i  = 4'h3;
        tick();
        valid_i = 1'b0;
        data_i  = 4'hC;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t4_data%0d", i),  data_o,  exp4_data[i]);
            check($sformatf("t4_valid%0d", i), valid_o, 1'b1);
            check($sformatf("t4_last%0d", i),  last_o,  (i == 3 || i == 7));
            if (i == 3) valid_i = 1'b1;
            if (i == 4) valid_i = 1'b0;
            tick();
        end
        check_idle4("t4_end");
        $display("txn bypass 4'h3,4'hc done checks=%0d", checks);

        // ---------------- 5: reset mid-frame ----------------
        valid_i = 1'b1;
        data_i  = 4'hF;
        tick();
        data_i  = 4'h9;
        check("t5_bit0", data_o, 1'b1);
        tick();
        valid_i = 1'b0;
        check("t5_bit1", data_o, 1'b1);
        check("t5_hold_ready", ready_o, 1'b0);
        tick();
        rst_n_i = 1'b0;
        #1;                         // still well before the next rising edge
        check_idle4("t5_async");
        check("t5_async_ready", ready_o, 1'b0);
        tick();
        rst_n_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("t5_quiet_valid%0d", i), valid_o, 1'b0);
            check($sformatf("t5_quiet_data%0d", i),  data_o,  1'b0);
        end
        check("t5_ready_after", ready_o, 1'b1);
        $display("txn reset mid-frame done checks=%0d", checks);

        // ---------------- 6: WIDTH=8, MSB first ----------------
        exp6_data = 16'b0000_0010_1000_0001;   // bit i = cycle i
        valid8_i = 1'b1;
        data8_i  = 8'h81;
        tick();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t6_data%0d", i),  data8_o,  exp6_data[i]);
            check($sformatf("t6_valid%0d", i), valid8_o, 1'b1);
            check($sformatf("t6_last%0d", i),  last8_o,  (i == 7 || i == 15));
            if (i == 0) data8_i = 8'h40;
            if (i == 1) valid8_i = 1'b0;
            tick();
        end
        check("t6_end_valid", valid8_o, 1'b0);
        check("t6_end_data",  data8_o,  1'b0);
        check("t6_end_last",  last8_o,  1'b0);
        $display("txn width8 msb-first 8'h81,8'h40 done checks=%0d", checks);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
